// File: rtl/condicionador_botoes.sv
// Pushbutton conditioner: 2-flop sync + per-channel debounce, clean levels and press pulses.
// Latency: a raw press is seen on the outputs DEBOUNCE+2 clock edges after the first edge that samples it.
// Backpressure: none; pulses are single-cycle and are not held or queued if unobserved.
//
// Ports:
//   clock          game clock, all state updates on the rising edge
//   reset_in       asynchronous active-low reset
//   botoes_in      7 raw game buttons, active-low, asynchronous
//   iniciar_in     raw start button, active-low, asynchronous
//   botoes         debounced game button levels, active-high
//   iniciar        debounced start level, active-high
//   iniciar_pulso  one-cycle pulse on a debounced start press
//   jogada_pulso   one-cycle pulse when a game-button press is accepted
//   jogada_codigo  one-hot code of the last accepted game button (held)
//   multiplo       more than one game button currently held
module condicionador_botoes #(
  parameter int DEBOUNCE = 4  // must be >= 2
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic [6:0] botoes_in,
  input  logic       iniciar_in,
  output logic [6:0] botoes,
  output logic       iniciar,
  output logic       iniciar_pulso,
  output logic       jogada_pulso,
  output logic [6:0] jogada_codigo,
  output logic       multiplo
);

  localparam int            CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE - 1);

  // Channel 7 is iniciar, channels 6..0 are the game buttons.
  logic [7:0]    bruto;
  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    estavel;
  logic [7:0]    estavel_prox;
  logic [7:0]    evento;
  logic [CW-1:0] cont      [8];
  logic [CW-1:0] cont_prox [8];
  logic [6:0]    evento_jogo;
  logic [6:0]    menor_evento;

  // Inputs are active-low; everything downstream is active-high.
  assign bruto = ~{iniciar_in, botoes_in};

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bruto;
      s2 <= s1;
    end
  end

  // The counter measures how long s2 has disagreed with the stable level;
  // any agreement restarts it, so only an unbroken run of DEBOUNCE
  // disagreeing samples moves the stable level.
  always_comb begin
    estavel_prox = estavel;
    for (int i = 0; i < 8; i++) begin
      cont_prox[i] = '0;
      if (s2[i] != estavel[i]) begin
        if (cont[i] == CONT_MAX) begin
          estavel_prox[i] = s2[i];
        end else begin
          cont_prox[i] = cont[i] + CW'(1);
        end
      end
    end
  end

  // Press = rising edge of the stable level; releases never generate events.
  assign evento      = estavel_prox & ~estavel;
  assign evento_jogo = evento[6:0];

  // Isolate the lowest set bit: simultaneous presses resolve to the lowest
  // index and the others are dropped for good.
  assign menor_evento = evento_jogo & (~evento_jogo + 7'd1);

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      estavel       <= '0;
      iniciar_pulso <= 1'b0;
      jogada_pulso  <= 1'b0;
      jogada_codigo <= '0;
      for (int i = 0; i < 8; i++) begin
        cont[i] <= '0;
      end
    end else begin
      estavel       <= estavel_prox;
      iniciar_pulso <= evento[7];
      jogada_pulso  <= |evento_jogo;
      if (|evento_jogo) begin
        jogada_codigo <= menor_evento;
      end
      for (int i = 0; i < 8; i++) begin
        cont[i] <= cont_prox[i];
      end
    end
  end

  assign botoes  = estavel[6:0];
  assign iniciar = estavel[7];

  // x & (x-1) clears the lowest set bit; anything left means two or more held.
  assign multiplo = |(botoes & (botoes - 7'd1));

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input conditioner between the raw active-low pushbuttons (7 game buttons plus `iniciar`) and the BitBakery top FSM and minigames. Each channel passes through a two-flop synchronizer and a per-channel debounce counter. The block outputs clean active-high levels and single-cycle press pulses. For the game buttons it also gives a registered one-hot code of the button pressed last.

## Interface
- `DEBOUNCE`, 4: consecutive `clock` cycles a synchronized sample must differ from the stable level before the stable level changes. Must be ≥ 2.
- `clock` in 1: game clock (divided clock). All state is updated on the rising edge.
- `reset_in` in 1: asynchronous, active-low reset. Drives every register to its reset value immediately.
- `botoes_in` in 7: raw buttons, active-low, asynchronous to `clock`.
- `iniciar_in` in 1: raw start button, active-low, asynchronous.
- `botoes` out 7: debounced button levels, active-high (1 = pressed). Reset value 0.
- `iniciar` out 1: debounced start level, active-high. Reset value 0.
- `iniciar_pulso` out 1: high for one cycle on a debounced press of `iniciar`. Reset value 0.
- `jogada_pulso` out 1: high for one cycle when a new game-button press is accepted. Reset value 0.
- `jogada_codigo` out 7: one-hot code of the most recently accepted button. Holds until the next accepted press. Reset value 0.
- `multiplo` out 1: high while more than one bit of `botoes` is 1. Combinational from the `botoes` registers. Reset value 0.

## Operation
- **Inversion.** Raw inputs are inverted at entry. All internal signals are active-high.
- **Synchronizer.** There are 8 channels (7 game buttons + `iniciar`). Each channel has two flops, s1 then s2, both reset to 0.
- **Debounce, per channel.** Each channel has a stable bit and a counter of width clog2(`DEBOUNCE`). Both reset to 0.
  - If s2 equals stable, the counter is cleared to 0.
  - If s2 differs from stable and counter < `DEBOUNCE`-1, the counter increments.
  - If s2 differs from stable and counter = `DEBOUNCE`-1, stable takes the value of s2 and the counter is cleared to 0.
  - As a result, any mismatch shorter than `DEBOUNCE` consecutive cycles is discarded.
- **Press event.** A channel has a press event on a clock edge where its stable bit goes 0→1. A 1→0 transition (release) is never an event.
- **`iniciar_pulso`.** Registered. Set to 1 on the same edge as the press event on the `iniciar` channel; cleared to 0 on the next edge.
- **Game buttons.** On an edge where one or more of the 7 game channels have a press event:
  - `jogada_pulso` is set to 1 for exactly one cycle.
  - `jogada_codigo` is loaded with the one-hot code of the lowest-index channel that had an event.
  - Other channels pressed on the same edge are dropped. They produce no later pulse.
- **Held buttons.** A button held while another button is pressed does not block the new press. Every press event is accepted independently.
- **No auto-repeat.** A button held indefinitely produces exactly one pulse.

## Timing
- **Press latency.** Let raw `botoes_in[i]` fall before edge 1 and stay low. Then:
  - s2 = 1 after edge 2.
  - stable, `botoes[i]`, `jogada_pulso` and `jogada_codigo` all update after edge 2+`DEBOUNCE`.
  - With `DEBOUNCE`=4 this is edge 6.
  - `jogada_pulso` is low again after edge 7.
- **Release latency.** Same as press latency: `botoes[i]` returns to 0 after edge 2+`DEBOUNCE` following the rising raw edge. No pulse is generated.
- **Pulse rate.** A new pulse needs a full release plus press, so pulses on one channel are at least 2·`DEBOUNCE` cycles apart.
- **Reset mid-operation.** Asserting `reset_in` immediately clears all outputs, counters and synchronizers. A pending pulse is lost.
- **Button held through reset.** When `reset_in` is released while a button is still held low, that button is treated as a fresh press. Its pulse fires `DEBOUNCE`+2 edges after the first clock edge after reset release.
- **Simultaneous `iniciar` and game button.** Both pulses fire on the same cycle. The two channels are independent.

## Test plan
- **Clean press.** Reset, then hold `botoes_in`=7'b1111011 for 20 cycles. Required: `botoes`=7'b0000100 after edge 6; `jogada_pulso`=1 for exactly one cycle (edge 6→7); `jogada_codigo`=7'b0000100 and holds after release.
- **Bounce rejection.** Pulse `botoes_in[0]` low for 3 cycles, high for 2 cycles, low for 3 cycles (`DEBOUNCE`=4). Required: `botoes`=0, no `jogada_pulso`, `jogada_codigo` unchanged. Then hold it low for 4+ cycles. Required: exactly one pulse, code 7'b0000001.
- **Simultaneous press.** Lower bits 5 and 2 of `botoes_in` on the same cycle. Required: one pulse, `jogada_codigo`=7'b0000100, `botoes`=7'b0100100, `multiplo`=1. Releasing both gives no pulse and `multiplo`=0.
- **Overlapping press.** Hold bit 1. Four cycles after it is accepted, press bit 6. Required: two pulses, codes 7'b0000010 then 7'b1000000.
- **Start button.** Hold `iniciar_in` low for 50 cycles. Required: `iniciar`=1 from edge 6 until 6 edges after release; `iniciar_pulso` high for exactly one cycle.
- **Reset mid-press.** Assert `reset_in` low during a held bit-3 press, after its pulse has fired. Required: all outputs 0 at once. Release reset with the button still held. Required: a new pulse with code 7'b0001000 at edge 6 after reset release.
